// File: rtl/ex_psr_nest.sv
// PSR, nested exception-state stack, EVECT, CPUID/COREID and scratch registers.
// Reads are write-through with zero latency, state updates on the next clk edge; no backpressure.
module ex_psr_nest #(
    parameter int          CONFIG_DW  = 64,
    parameter int          PSR_DW     = 10,
    parameter int          NEST_DEPTH = 4,
    parameter int          SR_NUM     = 8,
    parameter logic [7:0]  CPUID_VER  = 8'd2,
    parameter logic [9:0]  CPUID_REV  = 10'd0,
    parameter logic [7:0]  CPUID_FEAT = 8'hC3,
    localparam int         LW         = $clog2(NEST_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        psr_save,
    input  logic                        psr_restore,
    input  logic [CONFIG_DW-1:0]        save_epc,
    input  logic [CONFIG_DW-1:0]        save_elsa,
    input  logic [PSR_DW-1:0]           psr_nxt,
    input  logic [PSR_DW-1:0]           psr_we,
    output logic [PSR_DW-1:0]           msr_psr,
    input  logic [PSR_DW-1:0]           epsr_nxt,
    input  logic                        epsr_we,
    input  logic [CONFIG_DW-1:0]        epc_nxt,
    input  logic                        epc_we,
    input  logic [CONFIG_DW-1:0]        elsa_nxt,
    input  logic                        elsa_we,
    output logic [PSR_DW-1:0]           msr_epsr,
    output logic [CONFIG_DW-1:0]        msr_epc,
    output logic [CONFIG_DW-1:0]        msr_elsa,
    input  logic [CONFIG_DW-1:0]        evect_nxt,
    input  logic                        evect_we,
    output logic [CONFIG_DW-1:0]        msr_evect,
    input  logic [CONFIG_DW-1:0]        sr_nxt,
    input  logic [SR_NUM-1:0]           sr_we,
    output logic [CONFIG_DW*SR_NUM-1:0] msr_sr,
    output logic [LW-1:0]               nest_level,
    output logic                        nest_ovf,
    output logic                        nest_unf,
    input  logic                        nest_flag_clr,
    output logic [CONFIG_DW-1:0]        msr_cpuid,
    output logic [CONFIG_DW-1:0]        msr_coreid
);

    localparam int                IW        = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [PSR_DW-1:0] PSR_WMASK = ~PSR_DW'(4'hF);
    localparam logic [PSR_DW-1:0] PSR_RST   = PSR_DW'(10'h010);
    localparam logic [25:0]       CPUID_LO  = {CPUID_FEAT, CPUID_REV, CPUID_VER};

    logic [PSR_DW-1:0]    psr_q;
    logic [LW-1:0]        ptr_q;
    logic [CONFIG_DW-1:0] evect_q;
    logic                 ovf_q;
    logic                 unf_q;
    logic [PSR_DW-1:0]    epsr_q [NEST_DEPTH];
    logic [CONFIG_DW-1:0] epc_q  [NEST_DEPTH];
    logic [CONFIG_DW-1:0] elsa_q [NEST_DEPTH];
    logic [CONFIG_DW-1:0] sr_q   [SR_NUM];

    logic                 do_save;
    logic                 do_rest;
    logic                 full;
    logic                 empty;
    logic [IW-1:0]        top_idx;
    logic [IW-1:0]        wr_idx;
    logic [PSR_DW-1:0]    psr_sw;
    logic [PSR_DW-1:0]    psr_d;
    logic [LW-1:0]        ptr_d;

    assign do_save = psr_save;
    assign do_rest = psr_restore & ~psr_save;
    assign full    = (ptr_q == LW'(NEST_DEPTH));
    assign empty   = (ptr_q == '0);
    assign top_idx = empty ? '0 : IW'(ptr_q - LW'(1));
    assign wr_idx  = full ? IW'(NEST_DEPTH - 1) : IW'(ptr_q);
    assign psr_sw  = ((psr_q & ~psr_we) | (psr_nxt & psr_we)) & PSR_WMASK;

    always_comb begin
        psr_d = psr_sw;
        ptr_d = ptr_q;
        if (do_save) begin
            psr_d[7:4] = 4'b0001;
            if (!full) ptr_d = ptr_q + LW'(1);
        end else if (do_rest) begin
            psr_d[7:4] = epsr_q[top_idx][7:4];
            if (!empty) ptr_d = ptr_q - LW'(1);
        end
    end

    // Top-of-stack view after this cycle's update; a popped entry is cleared,
    // so the bottom level reads zero once the stack has fully unwound.
    always_comb begin
        msr_epsr = epsr_q[top_idx];
        msr_epc  = epc_q[top_idx];
        msr_elsa = elsa_q[top_idx];
        if (do_save) begin
            msr_epsr = psr_sw;
            msr_epc  = save_epc;
            msr_elsa = save_elsa;
        end else if (do_rest) begin
            if (ptr_q == LW'(1)) begin
                msr_epsr = '0;
                msr_epc  = '0;
                msr_elsa = '0;
            end else if (!empty) begin
                msr_epsr = epsr_q[IW'(ptr_q - LW'(2))];
                msr_epc  = epc_q[IW'(ptr_q - LW'(2))];
                msr_elsa = elsa_q[IW'(ptr_q - LW'(2))];
            end
        end else begin
            if (epsr_we) msr_epsr = epsr_nxt;
            if (epc_we)  msr_epc  = epc_nxt;
            if (elsa_we) msr_elsa = elsa_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            psr_q   <= PSR_RST;
            ptr_q   <= '0;
            evect_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                epsr_q[i] <= '0;
                epc_q[i]  <= '0;
                elsa_q[i] <= '0;
            end
        end else begin
            psr_q <= psr_d;
            ptr_q <= ptr_d;
            if (evect_we) evect_q <= evect_nxt;
            ovf_q <= (ovf_q & ~nest_flag_clr) | (do_save & full);
            unf_q <= (unf_q & ~nest_flag_clr) | (do_rest & empty);
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (do_save && wr_idx == IW'(i)) begin
                    epsr_q[i] <= psr_sw;
                    epc_q[i]  <= save_epc;
                    elsa_q[i] <= save_elsa;
                end else if (do_rest && !empty && top_idx == IW'(i)) begin
                    epsr_q[i] <= '0;
                    epc_q[i]  <= '0;
                    elsa_q[i] <= '0;
                end else if (!do_save && !do_rest && top_idx == IW'(i)) begin
                    if (epsr_we) epsr_q[i] <= epsr_nxt;
                    if (epc_we)  epc_q[i]  <= epc_nxt;
                    if (elsa_we) elsa_q[i] <= elsa_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SR_NUM; i++) begin
            if (sr_we[i]) sr_q[i] <= sr_nxt;
        end
    end

    for (genvar g = 0; g < SR_NUM; g++) begin : g_sr
        assign msr_sr[g*CONFIG_DW +: CONFIG_DW] = sr_we[g] ? sr_nxt : sr_q[g];
    end

    assign msr_psr    = psr_d;
    assign msr_evect  = evect_we ? evect_nxt : evect_q;
    assign nest_level = ptr_q;
    assign nest_ovf   = ovf_q;
    assign nest_unf   = unf_q;
    assign msr_cpuid  = {{(CONFIG_DW-26){1'b0}}, CPUID_LO};
    assign msr_coreid = '0;

endmodule

// File: tb/tb_ex_psr_nest.sv
// Directed bench for ex_psr_nest with hand-computed expected values.
module tb_ex_psr_nest;

    logic         clk = 1'b0;
    logic         rst;
    logic         psr_save, psr_restore;
    logic [63:0]  save_epc, save_elsa;
    logic [9:0]   psr_nxt, psr_we, msr_psr;
    logic [9:0]   epsr_nxt, msr_epsr;
    logic         epsr_we, epc_we, elsa_we, evect_we;
    logic [63:0]  epc_nxt, elsa_nxt, msr_epc, msr_elsa;
    logic [63:0]  evect_nxt, msr_evect, sr_nxt;
    logic [7:0]   sr_we;
    logic [511:0] msr_sr;
    logic [2:0]   nest_level;
    logic         nest_ovf, nest_unf, nest_flag_clr;
    logic [63:0]  msr_cpuid, msr_coreid;

    int checks   = 0;
    int failures = 0;

    ex_psr_nest dut (
        .clk(clk), .rst(rst),
        .psr_save(psr_save), .psr_restore(psr_restore),
        .save_epc(save_epc), .save_elsa(save_elsa),
        .psr_nxt(psr_nxt), .psr_we(psr_we), .msr_psr(msr_psr),
        .epsr_nxt(epsr_nxt), .epsr_we(epsr_we),
        .epc_nxt(epc_nxt), .epc_we(epc_we),
        .elsa_nxt(elsa_nxt), .elsa_we(elsa_we),
        .msr_epsr(msr_epsr), .msr_epc(msr_epc), .msr_elsa(msr_elsa),
        .evect_nxt(evect_nxt), .evect_we(evect_we), .msr_evect(msr_evect),
        .sr_nxt(sr_nxt), .sr_we(sr_we), .msr_sr(msr_sr),
        .nest_level(nest_level), .nest_ovf(nest_ovf), .nest_unf(nest_unf),
        .nest_flag_clr(nest_flag_clr),
        .msr_cpuid(msr_cpuid), .msr_coreid(msr_coreid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        psr_save = 0; psr_restore = 0; save_epc = '0; save_elsa = '0;
        psr_nxt = '0; psr_we = '0; epsr_nxt = '0; epsr_we = 0;
        epc_nxt = '0; epc_we = 0; elsa_nxt = '0; elsa_we = 0;
        evect_nxt = '0; evect_we = 0; sr_nxt = '0; sr_we = '0;
        nest_flag_clr = 0;
    endtask

    // Advance to just after the next rising edge with idle inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic save(input logic [63:0] epc);
        tick(); psr_save = 1; save_epc = epc;
    endtask

    initial begin
        idle();
        rst = 0;
        tick(); tick();
        rst = 1;

        // Reset state
        tick(); #3;
        chk("rst_psr",   64'(msr_psr), 64'h010);
        chk("rst_level", 64'(nest_level), 64'd0);
        chk("rst_epc",   msr_epc, 64'h0);
        chk("rst_ovf",   64'(nest_ovf), 64'd0);
        chk("rst_unf",   64'(nest_unf), 64'd0);
        chk("rst_evect", msr_evect, 64'h0);
        chk("cpuid",     msr_cpuid, 64'h30C0002);
        chk("coreid",    msr_coreid, 64'h0);

        // Software PSR write, then single save
        tick(); psr_we = 10'h0E0; psr_nxt = 10'h0E0; #3;
        chk("psr_wt", 64'(msr_psr), 64'h0F0);
        save(64'h1000); save_elsa = 64'h55; #3;
        chk("s1_epsr", 64'(msr_epsr), 64'h0F0);
        chk("s1_epc",  msr_epc, 64'h1000);
        chk("s1_elsa", msr_elsa, 64'h55);
        chk("s1_psr",  64'(msr_psr), 64'h010);
        tick(); #3;
        chk("s1_level", 64'(nest_level), 64'd1);
        chk("s1_epc_hold", msr_epc, 64'h1000);

        // Save with a DCE write in the same cycle
        save(64'h2000); psr_we = 10'h300; psr_nxt = 10'h200; #3;
        chk("s2_epsr", 64'(msr_epsr), 64'h210);
        chk("s2_psr",  64'(msr_psr), 64'h210);
        tick(); psr_restore = 1; #3;
        chk("r2_epc",  msr_epc, 64'h1000);
        chk("r2_epsr", 64'(msr_epsr), 64'h0F0);
        chk("r2_psr",  64'(msr_psr), 64'h210);
        tick(); psr_restore = 1; #3;
        chk("r1_epc", msr_epc, 64'h0);
        chk("r1_psr", 64'(msr_psr), 64'h2F0);
        tick(); #3;
        chk("r1_level", 64'(nest_level), 64'd0);
        tick(); psr_we = 10'h3F0; psr_nxt = 10'h000; #3;
        chk("psr_clear", 64'(msr_psr), 64'h000);

        // Three nested saves with distinct PSR[7:4], then three restores
        save(64'h100); psr_we = 10'h0F0; psr_nxt = 10'h020; #3;
        chk("n1_epsr", 64'(msr_epsr), 64'h020);
        save(64'h200); psr_we = 10'h0F0; psr_nxt = 10'h040; #3;
        chk("n2_epsr", 64'(msr_epsr), 64'h040);
        save(64'h300); psr_we = 10'h0F0; psr_nxt = 10'h080; #3;
        chk("n3_epsr", 64'(msr_epsr), 64'h080);
        chk("n3_psr",  64'(msr_psr), 64'h010);
        tick(); #3;
        chk("n_level", 64'(nest_level), 64'd3);
        tick(); psr_restore = 1; #3;
        chk("nr3_epc", msr_epc, 64'h200);
        chk("nr3_psr", 64'(msr_psr), 64'h080);
        tick(); psr_restore = 1; #3;
        chk("nr2_epc", msr_epc, 64'h100);
        chk("nr2_psr", 64'(msr_psr), 64'h040);
        tick(); psr_restore = 1; #3;
        chk("nr1_epc", msr_epc, 64'h0);
        chk("nr1_psr", 64'(msr_psr), 64'h020);
        tick(); #3;
        chk("nr_level", 64'(nest_level), 64'd0);

        // Overflow: NEST_DEPTH+1 saves
        for (int i = 1; i <= 5; i++) save(64'(i * 16));
        #3;
        chk("ovf_epc_wt", msr_epc, 64'h50);
        tick(); #3;
        chk("ovf_flag",  64'(nest_ovf), 64'd1);
        chk("ovf_level", 64'(nest_level), 64'd4);
        chk("ovf_epc",   msr_epc, 64'h50);
        save(64'h60); nest_flag_clr = 1; #3;
        tick(); #3;
        chk("ovf_setwins", 64'(nest_ovf), 64'd1);
        chk("ovf_epc2",    msr_epc, 64'h60);
        tick(); nest_flag_clr = 1;
        tick(); #3;
        chk("ovf_clr", 64'(nest_ovf), 64'd0);
        tick(); psr_restore = 1; #3;
        chk("op4_epc", msr_epc, 64'h30);
        tick(); psr_restore = 1; #3;
        chk("op3_epc", msr_epc, 64'h20);
        tick(); psr_restore = 1; #3;
        chk("op2_epc", msr_epc, 64'h10);
        tick(); psr_restore = 1; #3;
        chk("op1_epc", msr_epc, 64'h0);
        tick(); #3;
        chk("op_level", 64'(nest_level), 64'd0);

        // Underflow
        tick(); psr_we = 10'h3F0; psr_nxt = 10'h0F0; #3;
        chk("unf_pre_psr", 64'(msr_psr), 64'h0F0);
        tick(); psr_restore = 1; #3;
        chk("unf_psr", 64'(msr_psr), 64'h000);
        chk("unf_epc", msr_epc, 64'h0);
        tick(); #3;
        chk("unf_flag",  64'(nest_unf), 64'd1);
        chk("unf_level", 64'(nest_level), 64'd0);
        tick(); nest_flag_clr = 1;
        tick(); #3;
        chk("unf_clr", 64'(nest_unf), 64'd0);

        // Save and restore together behave as save
        save(64'h777); psr_restore = 1; #3;
        chk("sr_epc", msr_epc, 64'h777);
        chk("sr_psr", 64'(msr_psr), 64'h010);
        tick(); #3;
        chk("sr_level", 64'(nest_level), 64'd1);
        chk("sr_unf",   64'(nest_unf), 64'd0);

        // Software top-entry writes, ignored during save
        tick(); epc_we = 1; epc_nxt = 64'hABC; epsr_we = 1; epsr_nxt = 10'h3F0;
        elsa_we = 1; elsa_nxt = 64'hCD; #3;
        chk("sw_epc",  msr_epc, 64'hABC);
        chk("sw_epsr", 64'(msr_epsr), 64'h3F0);
        tick(); #3;
        chk("sw_elsa_hold", msr_elsa, 64'hCD);
        save(64'h900); epc_we = 1; epc_nxt = 64'hBAD; #3;
        chk("sw_ign_epc", msr_epc, 64'h900);
        tick(); psr_restore = 1; #3;
        chk("sw_pop_epc", msr_epc, 64'hABC);

        // Scratch register and EVECT write-through and hold
        tick(); sr_we = 8'h04; sr_nxt = 64'hDEAD; evect_we = 1; evect_nxt = 64'h8000; #3;
        chk("sr2_wt",    msr_sr[2*64 +: 64], 64'hDEAD);
        chk("evect_wt",  msr_evect, 64'h8000);
        tick(); #3;
        chk("sr2_hold",   msr_sr[2*64 +: 64], 64'hDEAD);
        chk("evect_hold", msr_evect, 64'h8000);

        // Reset mid-sequence with a pending save
        tick(); rst = 0; psr_save = 1; save_epc = 64'h123;
        tick(); rst = 1; #3;
        chk("mrst_level", 64'(nest_level), 64'd0);
        chk("mrst_psr",   64'(msr_psr), 64'h010);
        chk("mrst_epc",   msr_epc, 64'h0);
        chk("mrst_evect", msr_evect, 64'h0);
        chk("mrst_sr2",   msr_sr[2*64 +: 64], 64'hDEAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
